cmos_reg_seq: RTL and testbench

CMOS_REG_SEQ -- requirements
Module: cmos_reg_seq

---
 rtl/cmos_reg_seq_if.sv | 30 +++
 rtl/cmos_reg_seq.sv | 189 ++++++++++++++++++
 tb/tb_cmos_reg_seq.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmos_reg_seq_if.sv
// Bus bundle between the register sequencer, its configuration ROM and the I2C write engine.
// The sequencer is the master: it drives the ROM address and the I2C request, and receives ROM data and completion.
interface cmos_reg_seq_if #(
   parameter int IDX_W = 9
);
   logic [IDX_W-1:0] rom_index;
   logic [25:0]      rom_data;
   logic             i2c_start;
   logic [31:0]      i2c_data;
   logic             i2c_tr_end;
   logic             i2c_nack;

   modport master (
      output rom_index,
      input  rom_data,
      output i2c_start,
      output i2c_data,
      input  i2c_tr_end,
      input  i2c_nack
   );

   modport slave (
      input  rom_index,
      output rom_data,
      input  i2c_start,
      input  i2c_data,
      output i2c_tr_end,
      output i2c_nack
   );
endinterface

// File: rtl/cmos_reg_seq.sv
// Camera register sequencer: walks a ROM table of {op, reg_addr, val} entries, issuing I2C writes
// (with NACK retry), millisecond delays, skips and an end marker, then reports done or error.
module cmos_reg_seq #(
   parameter int         NUM_REGS    = 253,
   parameter int         IDX_W       = 9,
   parameter logic [7:0] DEV_ADDR    = 8'h78,
   parameter int         MAX_RETRY   = 3,
   parameter int         CLKS_PER_MS = 25000,
   parameter int         GAP_CLKS    = 16
) (
   input  logic             clk_25M,
   input  logic             camera_rstn,
   input  logic             initial_en,
   cmos_reg_seq_if.master   bus,
   output logic             busy,
   output logic             reg_conf_done,
   output logic             reg_conf_err,
   output logic [IDX_W-1:0] err_index
);
   localparam int DLY_W  = $clog2(255 * CLKS_PER_MS + 1);
   localparam int RTRY_W = $clog2(MAX_RETRY + 2);
   localparam int GAP_W  = $clog2(GAP_CLKS + 2);

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, WRITE, WAIT_END, GAP, DELAY, DONE, ERROR
   } state_t;

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic [23:0]        entry_reg, entry_next;
   logic [RTRY_W-1:0]  retry_reg, retry_next;
   logic               rewrite_reg, rewrite_next;
   logic [GAP_W-1:0]   gap_reg, gap_next;
   logic [DLY_W-1:0]   dly_reg, dly_next;
   logic               start_reg, start_next;
   logic [31:0]        data_reg, data_next;
   logic               busy_reg, busy_next;
   logic               done_reg, done_next;
   logic               err_reg, err_next;
   logic [IDX_W-1:0]   erridx_reg, erridx_next;
   logic               en_prev_reg;
   logic               advance;

   always_ff @(posedge clk_25M or negedge camera_rstn) begin
      if (!camera_rstn) begin
         state_reg   <= IDLE;
         idx_reg     <= '0;
         entry_reg   <= '0;
         retry_reg   <= '0;
         rewrite_reg <= 1'b0;
         gap_reg     <= '0;
         dly_reg     <= '0;
         start_reg   <= 1'b0;
         data_reg    <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
         erridx_reg  <= '0;
         en_prev_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         entry_reg   <= entry_next;
         retry_reg   <= retry_next;
         rewrite_reg <= rewrite_next;
         gap_reg     <= gap_next;
         dly_reg     <= dly_next;
         start_reg   <= start_next;
         data_reg    <= data_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         err_reg     <= err_next;
         erridx_reg  <= erridx_next;
         en_prev_reg <= initial_en;
      end
   end

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      entry_next   = entry_reg;
      retry_next   = retry_reg;
      rewrite_next = rewrite_reg;
      gap_next     = gap_reg;
      dly_next     = dly_reg;
      start_next   = start_reg;
      data_next    = data_reg;
      busy_next    = busy_reg;
      done_next    = done_reg;
      err_next     = err_reg;
      erridx_next  = erridx_reg;
      advance      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (initial_en) begin
               idx_next   = '0;
               busy_next  = 1'b1;
               state_next = FETCH;
            end
         end
         FETCH: state_next = DECODE;
         DECODE: begin
            entry_next = bus.rom_data[23:0];
            retry_next = '0;
            case (bus.rom_data[25:24])
               2'b00: state_next = WRITE;
               2'b01: begin
                  dly_next   = DLY_W'(bus.rom_data[7:0]) * DLY_W'(CLKS_PER_MS);
                  state_next = DELAY;
               end
               2'b10: begin
                  done_next  = 1'b1;
                  busy_next  = 1'b0;
                  state_next = DONE;
               end
               default: advance = 1'b1;
            endcase
         end
         WRITE: begin
            data_next  = {DEV_ADDR, entry_reg};
            start_next = 1'b1;
            state_next = WAIT_END;
         end
         WAIT_END: begin
            if (bus.i2c_tr_end) begin
               start_next = 1'b0;
               gap_next   = GAP_W'(GAP_CLKS);
               if (!bus.i2c_nack) begin
                  rewrite_next = 1'b0;
                  state_next   = GAP;
               end else if (retry_reg < RTRY_W'(MAX_RETRY)) begin
                  retry_next   = retry_reg + 1'b1;
                  rewrite_next = 1'b1;
                  state_next   = GAP;
               end else begin
                  erridx_next = idx_reg;
                  err_next    = 1'b1;
                  busy_next   = 1'b0;
                  state_next  = ERROR;
               end
            end
         end
         GAP: begin
            // Counter is loaded with GAP_CLKS and exits on 1, so GAP lasts GAP_CLKS clocks.
            if (gap_reg <= GAP_W'(1)) begin
               if (rewrite_reg) state_next = WRITE;
               else             advance    = 1'b1;
            end else begin
               gap_next = gap_reg - 1'b1;
            end
         end
         DELAY: begin
            if (dly_reg <= DLY_W'(1)) advance  = 1'b1;
            else                      dly_next = dly_reg - 1'b1;
         end
         DONE, ERROR: begin
            // Only a fresh 0->1 edge restarts; a level held from the previous run is ignored.
            if (initial_en && !en_prev_reg) begin
               done_next  = 1'b0;
               err_next   = 1'b0;
               idx_next   = '0;
               busy_next  = 1'b1;
               state_next = FETCH;
            end
         end
         default: state_next = IDLE;
      endcase

      if (advance) begin
         if (idx_reg == IDX_W'(NUM_REGS - 1)) begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = DONE;
         end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = FETCH;
         end
      end
   end

   assign bus.rom_index = idx_reg;
   assign bus.i2c_start = start_reg;
   assign bus.i2c_data  = data_reg;
   assign busy          = busy_reg;
   assign reg_conf_done = done_reg;
   assign reg_conf_err  = err_reg;
   assign err_index     = erridx_reg;
endmodule

// File: tb/tb_cmos_reg_seq.sv
// Self-checking bench for cmos_reg_seq: ROM and I2C slave models plus a table-walking reference
// model that predicts the transaction list and final status for directed and random tables.
module tb_cmos_reg_seq;
   localparam int         NUM_REGS    = 10;
   localparam int         IDX_W       = 4;
   localparam logic [7:0] DEV_ADDR    = 8'h78;
   localparam int         MAX_RETRY   = 3;
   localparam int         CLKS_PER_MS = 10;
   localparam int         GAP_CLKS    = 16;
   localparam int         DEPTH       = 1 << IDX_W;

   logic             clk = 1'b0;
   logic             rstn;
   logic             initial_en;
   logic             busy, done, err;
   logic [IDX_W-1:0] err_index;

   cmos_reg_seq_if #(.IDX_W(IDX_W)) bus ();

   cmos_reg_seq #(
      .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .DEV_ADDR(DEV_ADDR), .MAX_RETRY(MAX_RETRY),
      .CLKS_PER_MS(CLKS_PER_MS), .GAP_CLKS(GAP_CLKS)
   ) dut (
      .clk_25M(clk), .camera_rstn(rstn), .initial_en(initial_en), .bus(bus),
      .busy(busy), .reg_conf_done(done), .reg_conf_err(err), .err_index(err_index)
   );

   always #20 clk = ~clk;

   logic [25:0] rom_mem [DEPTH];
   int          nack_cnt [DEPTH];
   int          attempts [DEPTH];

   always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_index];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // reference model results
   logic [31:0] exp_q[$];
   bit          exp_done, exp_err;
   int          exp_err_idx, exp_max_idx;
   // monitor observations
   logic [31:0] obs_q[$];
   int          gap_q[$];
   int          stab_viol, both_viol, max_idx_obs, low_run, gap_bad;
   bit          start_d, first_tx, spurious_en;
   logic [31:0] held;
   int          sl_lat, sl_idx;

   task automatic model_run();
      int  idx = 0;
      bit  fin = 0;
      bit  ok;
      exp_q.delete();
      exp_done = 0; exp_err = 0; exp_err_idx = 0;
      while (!fin) begin
         exp_max_idx = idx;
         case (rom_mem[idx][25:24])
            2'b00: begin
               ok = 0;
               for (int a = 0; a <= MAX_RETRY; a++) begin
                  exp_q.push_back({DEV_ADDR, rom_mem[idx][23:0]});
                  if (a >= nack_cnt[idx]) begin ok = 1; break; end
               end
               if (!ok) begin exp_err = 1; exp_err_idx = idx; fin = 1; end
            end
            2'b10: begin exp_done = 1; fin = 1; end
            default: ;
         endcase
         if (!fin) begin
            if (idx == NUM_REGS - 1) begin exp_done = 1; fin = 1; end
            else idx++;
         end
      end
   endtask

   task automatic set_entry(input int i, input logic [1:0] op, input logic [15:0] addr,
                            input logic [7:0] val, input int nacks);
      rom_mem[i]  = {op, addr, val};
      nack_cnt[i] = nacks;
   endtask

   task automatic fill_writes();
      for (int i = 0; i < DEPTH; i++) set_entry(i, 2'b00, 16'h3600 + 16'(i), 8'(i * 3), 0);
   endtask

   task automatic prep();
      model_run();
      for (int i = 0; i < DEPTH; i++) attempts[i] = 0;
      obs_q.delete(); gap_q.delete();
      stab_viol = 0; both_viol = 0; max_idx_obs = 0; first_tx = 1;
   endtask

   task automatic start_seq();
      @(negedge clk) initial_en = 1'b0;
      repeat (2) @(negedge clk);
      initial_en = 1'b1;
   endtask

   task automatic finish_seq(input string tag);
      int cyc = 0;
      repeat (2) @(negedge clk);
      while (!(done || err) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, ":timeout"}, 32'(cyc < 20000), 1);
      repeat (2) @(negedge clk);
      check({tag, ":ntrans"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s:data%0d", tag, i), obs_q[i], exp_q[i]);
      check({tag, ":done"}, 32'(done), 32'(exp_done));
      check({tag, ":err"}, 32'(err), 32'(exp_err));
      if (exp_err) check({tag, ":err_index"}, 32'(err_index), 32'(exp_err_idx));
      check({tag, ":busy"}, 32'(busy), 0);
      check({tag, ":max_idx"}, 32'(max_idx_obs), 32'(exp_max_idx));
      gap_bad = 0;
      foreach (gap_q[i]) if (gap_q[i] < GAP_CLKS) gap_bad++;
      check({tag, ":short_gaps"}, 32'(gap_bad), 0);
      check({tag, ":data_unstable"}, 32'(stab_viol), 0);
      check({tag, ":done_and_err"}, 32'(both_viol), 0);
   endtask

   initial begin
      int r;
      logic [1:0] op;
      rstn = 1'b0; initial_en = 1'b0; spurious_en = 0;
      bus.i2c_tr_end = 1'b0; bus.i2c_nack = 1'b0;
      start_d = 0; low_run = 0; first_tx = 1; sl_lat = -1;
      fill_writes();

      fork
         forever begin : monitor
            @(negedge clk);
            if (done && err) both_viol++;
            if (busy && int'(bus.rom_index) > max_idx_obs) max_idx_obs = int'(bus.rom_index);
            if (bus.i2c_start) begin
               if (!start_d) begin
                  obs_q.push_back(bus.i2c_data);
                  held = bus.i2c_data;
                  if (!first_tx) gap_q.push_back(low_run);
                  first_tx = 0;
                  $display("txn idx=%0d data=%h idle_before=%0d", bus.rom_index, bus.i2c_data, low_run);
               end else if (bus.i2c_data !== held) stab_viol++;
               low_run = 0;
            end else low_run++;
            start_d = bus.i2c_start;
         end
         forever begin : i2c_slave
            @(negedge clk);
            bus.i2c_tr_end = 1'b0; bus.i2c_nack = 1'b0;
            if (!bus.i2c_start) begin
               sl_lat = -1;
               if (spurious_en && $urandom_range(0, 15) == 0) begin
                  bus.i2c_tr_end = 1'b1;
                  bus.i2c_nack   = 1'($urandom_range(0, 1));
               end
            end else if (sl_lat == -1) sl_lat = $urandom_range(0, 4);
            else if (sl_lat == 0) begin
               sl_idx = int'(bus.rom_index);
               bus.i2c_tr_end = 1'b1;
               bus.i2c_nack   = (attempts[sl_idx] < nack_cnt[sl_idx]);
               attempts[sl_idx]++;
               sl_lat = -2;
            end else if (sl_lat > 0) sl_lat--;
         end
      join_none

      // reset state
      repeat (3) @(negedge clk);
      check("rst:busy", 32'(busy), 0);
      check("rst:done", 32'(done), 0);
      check("rst:err", 32'(err), 0);
      check("rst:start", 32'(bus.i2c_start), 0);
      check("rst:data", bus.i2c_data, 0);
      check("rst:rom_index", 32'(bus.rom_index), 0);
      check("rst:err_index", 32'(err_index), 0);

      // three acked writes, started by initial_en already high at reset release
      set_entry(0, 2'b00, 16'h3103, 8'h11, 0);
      set_entry(1, 2'b00, 16'h3104, 8'h12, 0);
      set_entry(2, 2'b00, 16'h3105, 8'h13, 0);
      set_entry(3, 2'b10, 16'h0000, 8'h00, 0);
      prep();
      initial_en = 1'b1;
      @(negedge clk) #5 rstn = 1'b1;
      @(posedge clk) #1;
      check("three:first_clk_busy", 32'(busy), 1);
      check("three:first_clk_index", 32'(bus.rom_index), 0);
      finish_seq("three");
      if (obs_q.size() > 0) check("three:first_word", obs_q[0], 32'h78310311);
      check("three:ngaps", 32'(gap_q.size()), 2);
      if (gap_q.size() > 0) check("three:gap_bound", 32'(gap_q[0] <= GAP_CLKS + 8), 1);

      // 5 ms delay entry between two writes
      fill_writes();
      set_entry(0, 2'b00, 16'h3000, 8'h01, 0);
      set_entry(1, 2'b01, 16'h0000, 8'd5, 0);
      set_entry(2, 2'b00, 16'h3001, 8'h02, 0);
      set_entry(3, 2'b10, 16'h0000, 8'h00, 0);
      prep(); start_seq(); finish_seq("delay");
      if (gap_q.size() > 0)
         check("delay:idle_len", 32'(gap_q[0] >= GAP_CLKS + 50 && gap_q[0] <= GAP_CLKS + 58), 1);

      // persistent NACK on entry 4
      fill_writes();
      nack_cnt[4] = 4;
      prep(); start_seq(); finish_seq("nack_abort");
      check("nack_abort:attempts", 32'(attempts[4]), 32'(MAX_RETRY + 1));

      // single NACK then ack
      fill_writes();
      nack_cnt[1] = 1;
      set_entry(3, 2'b10, 16'h0000, 8'h00, 0);
      prep(); start_seq(); finish_seq("nack_once");

      // end marker at index 2 of 10
      fill_writes();
      set_entry(2, 2'b10, 16'h0000, 8'h00, 0);
      prep(); start_seq(); finish_seq("end_mark");

      // reset pulse during WAIT_END, restart from index 0, no restart while initial_en stays high
      fill_writes();
      set_entry(0, 2'b00, 16'h3103, 8'h11, 0);
      set_entry(1, 2'b00, 16'h3104, 8'h12, 0);
      set_entry(2, 2'b00, 16'h3105, 8'h13, 0);
      set_entry(3, 2'b10, 16'h0000, 8'h00, 0);
      prep(); start_seq();
      r = 0;
      while (!bus.i2c_start && r < 2000) begin @(negedge clk); r++; end
      check("midrst:saw_start", 32'(bus.i2c_start), 1);
      #5 rstn = 1'b0;
      #1;
      check("midrst:start", 32'(bus.i2c_start), 0);
      check("midrst:data", bus.i2c_data, 0);
      check("midrst:busy", 32'(busy), 0);
      check("midrst:rom_index", 32'(bus.rom_index), 0);
      repeat (3) @(negedge clk);
      prep();
      #5 rstn = 1'b1;
      finish_seq("midrst_restart");
      repeat (60) @(negedge clk);
      check("hold_en:busy", 32'(busy), 0);
      check("hold_en:done", 32'(done), 1);
      check("hold_en:no_new_txn", 32'(obs_q.size()), 32'(exp_q.size()));
      prep(); start_seq(); finish_seq("toggle_restart");

      // randomized tables with random NACK patterns and stray completion pulses
      spurious_en = 1;
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < DEPTH; i++) begin
            r  = $urandom_range(0, 99);
            op = (r < 60) ? 2'b00 : (r < 75) ? 2'b01 : (r < 85) ? 2'b10 : 2'b11;
            set_entry(i, op, 16'($urandom),
                      (op == 2'b01) ? 8'($urandom_range(0, 3)) : 8'($urandom),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
         end
         prep(); start_seq(); finish_seq($sformatf("rand%0d", t));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
